mem_port_ctrl: RTL

MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_rr_arbiter.sv | 32 +++
 rtl/mem_port_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared defaults, FSM states and latched request record for mem_port_ctrl
package mem_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
        logic                  port;
    } req_t;
endpackage

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: 2-way request arbiter
// MEM_ROUND_ROBIN_EN: contention goes to the port not granted last; otherwise port 0 always wins
module mem_rr_arbiter (
`ifdef MEM_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset_n,
    input  logic       update,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_id
);
`ifdef MEM_ROUND_ROBIN_EN
    logic last;

    // remember the last granted port; port 1 after reset so port 0 is favoured first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            last <= 1'b1;
        else if (update)
            last <= grant_id;
    end

    // on contention pick the port that was not granted last
    always_comb grant_id = (&req) ? ~last : req[1];
`else
    // fixed priority: port 1 only wins when port 0 is not asking
    always_comb grant_id = req[1] & ~req[0];
`endif

    assign grant = (req == 2'b00) ? 2'b00 : (grant_id ? 2'b10 : 2'b01);
endmodule

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: two request ports sharing one synchronous memory_storage, one transaction in flight
// MEM_ROUND_ROBIN_EN: alternate grants on contention (default build: port 0 fixed priority)
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = 1
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_write,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic [DATA_W-1:0] p0_rsp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_write,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic [DATA_W-1:0] p1_rsp_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);
    localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    state_t            state, next;
    req_t              r;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        grant;
    logic              gid;
    logic              hs;

    mem_rr_arbiter u_arb (
`ifdef MEM_ROUND_ROBIN_EN
        .clk      (clk),
        .reset_n  (reset_n),
        .update   (hs),
`endif
        .req      ({p1_req_valid, p0_req_valid}),
        .grant    (grant),
        .grant_id (gid)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next;
    end

    // next state: writes finish after ISSUE, reads wait out the memory latency then respond
    always_comb begin
        next = state == IDLE  ? (hs ? ISSUE : IDLE) :
               state == ISSUE ? (r.write ? IDLE : WAIT) :
               state == WAIT  ? (cnt == '0 ? RESP : WAIT) : IDLE;
    end

    // handshake only in IDLE and never while reset is held; strobes follow the latched request
    always_comb begin
        hs           = state == IDLE && reset_n && (p0_req_valid || p1_req_valid);
        p0_req_ready = hs && grant[0];
        p1_req_ready = hs && grant[1];
        mem_write    = state == ISSUE && r.write;
        p0_rsp_valid = state == RESP && !r.port;
        p1_rsp_valid = state == RESP && r.port;
    end

    // latch the granted request, count the read latency and capture read data on the last WAIT edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r     <= '0;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            if (hs)
                r <= '{write: gid ? p1_req_write : p0_req_write,
                       addr:  gid ? p1_req_addr  : p0_req_addr,
                       wdata: gid ? p1_req_wdata : p0_req_wdata,
                       port:  gid};
            if (state == ISSUE)
                cnt <= CW'(READ_LAT - 1);
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == WAIT && cnt == '0)
                rdata <= mem_dataout;
        end
    end

    // the latched request doubles as the memory bus, so it holds between transactions
    assign mem_address  = r.addr;
    assign mem_datain   = r.wdata;
    assign p0_rsp_rdata = rdata;
    assign p1_rsp_rdata = rdata;
endmodule
